spi_flash_seq: RTL and testbench

//  Command sequencer sitting between the AXI-side request logic and a byte-level SPI shift engine.

---
 rtl/spi_flash_seq.sv | 212 +++++++++++++++++++++
 tb/tb_spi_flash_seq.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_seq.sv
// spi_flash_seq: turns single read/write requests into SPI NOR flash command
// sequences (READ 0x03, WREN 0x06, PAGE PROGRAM 0x02, RDSR 0x05 polling) for a
// byte-level shift engine, and marks the byte that closes each CS frame.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready              request handshake (ready only when idle)
//   req_write, req_addr, req_wdata   request: 1=page program, byte address, payload
//   rsp_valid/rsp_ready              response handshake
//   rsp_rdata, rsp_err               read payload (0 for writes), poll timeout flag
//   spi_start, spi_tx_byte, spi_last byte issue pulse, byte, end-of-frame marker
//   spi_busy, spi_done, spi_rx_byte  engine status, byte-complete pulse, MISO byte
//
// Optional feature: define FLASH_POLL_TIMEOUT_EN to bound RDSR polling at
// POLL_LIMIT polls and report rsp_err=1 on expiry. Undefined: polls until WIP=0.
module spi_flash_seq #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned POLL_LIMIT = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  spi_start,
  output logic [7:0]            spi_tx_byte,
  output logic                  spi_last,
  input  logic                  spi_busy,
  input  logic                  spi_done,
  input  logic [7:0]            spi_rx_byte
);

  localparam int unsigned DATA_BYTES = DATA_WIDTH / 8;
  localparam int unsigned ADDR_BYTES = ADDR_WIDTH / 8;
  localparam int unsigned CNT_W      = $clog2(DATA_BYTES) + 1;

  // Elaboration-time parameter sanity
  if ((DATA_WIDTH % 8) != 0 || (ADDR_WIDTH % 8) != 0 || POLL_LIMIT < 1 ||
      ADDR_BYTES > DATA_BYTES) begin : g_cfg_check
    $error("spi_flash_seq: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WREN, S_CMD, S_ADDR, S_DATA, S_POLL, S_RESP
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;      // bytes remaining after the current one
  logic                  pend;     // a byte has been issued, waiting for spi_done
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_sr;  // shifts left as address bytes are issued
  logic [DATA_WIDTH-1:0] data_sr;  // shifts left as payload bytes are issued

`ifdef FLASH_POLL_TIMEOUT_EN
  localparam int unsigned PCNT_W = $clog2(POLL_LIMIT + 1);
  logic [PCNT_W-1:0] poll_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  logic       issue_c;
  logic [7:0] tx_c;
  logic       last_c;

  // Byte to send and CS-closing flag for the current byte state
  always_comb begin
    tx_c   = 8'h00;
    last_c = 1'b0;
    case (state)
      S_WREN: begin
        tx_c   = 8'h06;
        last_c = 1'b1;
      end
      S_CMD:  tx_c = write_q ? 8'h02 : 8'h03;
      S_ADDR: tx_c = addr_sr[ADDR_WIDTH-1 -: 8];
      S_DATA: begin
        tx_c   = write_q ? data_sr[DATA_WIDTH-1 -: 8] : 8'h00;
        last_c = (cnt == '0);
      end
      S_POLL: begin
        tx_c   = (cnt != '0) ? 8'h05 : 8'h00;
        last_c = (cnt == '0);
      end
      default: ;
    endcase
  end

  assign issue_c = (state != S_IDLE) && (state != S_RESP) && !pend && !spi_busy;

  // Sequencer state, byte issue and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pend        <= 1'b0;
      write_q     <= 1'b0;
      addr_sr     <= '0;
      data_sr     <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      spi_start   <= 1'b0;
      spi_tx_byte <= 8'h00;
      spi_last    <= 1'b0;
`ifdef FLASH_POLL_TIMEOUT_EN
      rsp_err     <= 1'b0;
      poll_cnt    <= '0;
`endif
    end else begin
      spi_start <= 1'b0;
      if (issue_c) begin
        spi_start   <= 1'b1;
        spi_tx_byte <= tx_c;
        spi_last    <= last_c;
        pend        <= 1'b1;
        if (state == S_ADDR) addr_sr <= addr_sr << 8;
        if (state == S_DATA) data_sr <= data_sr << 8;
      end
      case (state)
        S_IDLE: begin
`ifdef FLASH_POLL_TIMEOUT_EN
          poll_cnt <= '0;
`endif
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            write_q   <= req_write;
            addr_sr   <= req_addr;
            data_sr   <= req_wdata;
            rsp_rdata <= '0;
`ifdef FLASH_POLL_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state     <= req_write ? S_WREN : S_CMD;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          if (pend && spi_done) begin
            pend <= 1'b0;
            case (state)
              S_WREN: state <= S_CMD;
              S_CMD: begin
                state <= S_ADDR;
                cnt   <= CNT_W'(ADDR_BYTES - 1);
              end
              S_ADDR: begin
                if (cnt == '0) begin
                  state <= S_DATA;
                  cnt   <= CNT_W'(DATA_BYTES - 1);
                end else begin
                  cnt <= cnt - CNT_W'(1);
                end
              end
              S_DATA: begin
                // First received byte ends up in the MSBs after all shifts
                if (!write_q) rsp_rdata <= {rsp_rdata[DATA_WIDTH-9:0], spi_rx_byte};
                if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
                end else if (write_q) begin
                  state <= S_POLL;
                  cnt   <= CNT_W'(1);
                end else begin
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
                end
              end
              S_POLL: begin
                if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
                end else begin
`ifdef FLASH_POLL_TIMEOUT_EN
                  poll_cnt <= poll_cnt + PCNT_W'(1);
`endif
                  // Status bit 0 is WIP
                  if (!spi_rx_byte[0]) begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                  end
`ifdef FLASH_POLL_TIMEOUT_EN
                  else if (poll_cnt == PCNT_W'(POLL_LIMIT - 1)) begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                  end
`endif
                  else begin
                    cnt <= CNT_W'(1);
                  end
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_seq.sv
// tb_spi_flash_seq: table-driven and randomized check of spi_flash_seq against a
// byte-level SPI engine plus a sparse flash memory model kept in the bench.
module tb_spi_flash_seq;
  localparam int unsigned DW = 128;
  localparam int unsigned AW = 24;
  localparam int unsigned DB = DW / 8;
  localparam int unsigned AB = AW / 8;
  localparam int unsigned PL = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          spi_start, spi_last, spi_busy, spi_done;
  logic [7:0]    spi_tx_byte, spi_rx_byte;

  spi_flash_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .POLL_LIMIT(PL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .spi_start(spi_start), .spi_tx_byte(spi_tx_byte), .spi_last(spi_last),
    .spi_busy(spi_busy), .spi_done(spi_done), .spi_rx_byte(spi_rx_byte)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            wip;        // RDSR polls answering WIP=1 after the program
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_polls;  // RDSR transactions expected
    int            hold;       // cycles rsp_ready stays low
    bit            keep_valid; // present another request while the response waits
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cyc = 0;

  // Flash model state
  logic [7:0]    mem [int];
  logic [8:0]    mosi_q [$];   // {spi_last, byte} as issued
  logic [8:0]    exp_q [$];
  int            tidx = 0;
  logic [7:0]    op = 8'h00;
  logic [AW-1:0] fl_addr = '0;
  int            wip_cfg = 0;
  int            wip_left = 0;
  int            rdsr_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_rd(input int a);
    int k;
    k = a & 32'h00FF_FFFF;
    return mem.exists(k) ? mem[k] : 8'(k * 13 + 7);
  endfunction

  // Device side of one byte: returns MISO byte, tracks CS frames via last
  function automatic logic [7:0] flash_byte(input logic [7:0] b, input logic last);
    logic [7:0] rx;
    int         k;
    rx = 8'hFF;
    if (tidx == 0) begin
      op = b;
    end else if (op == 8'h03 || op == 8'h02) begin
      if (tidx <= AB) begin
        fl_addr = {fl_addr[AW-9:0], b};
      end else begin
        k = (int'(fl_addr) + tidx - 1 - AB) & 32'h00FF_FFFF;
        if (op == 8'h03) rx = mem_rd(k);
        else mem[k] = b;
      end
    end else if (op == 8'h05 && tidx == 1) begin
      rx = (wip_left > 0) ? 8'h01 : 8'h00;
      if (wip_left > 0) wip_left--;
    end
    if (last) begin
      if (op == 8'h05) rdsr_count++;
      if (op == 8'h02) wip_left = wip_cfg;
      tidx = 0;
    end else begin
      tidx++;
    end
    return rx;
  endfunction

  // Byte engine: busy for 1..3 cycles after each start, then a done pulse
  initial begin
    int         lat;
    logic       busy_was;
    logic [7:0] pend_rx;
    lat = 0;
    pend_rx = 8'h00;
    spi_busy = 1'b0;
    spi_done = 1'b0;
    spi_rx_byte = 8'h00;
    forever begin
      @(posedge clk); #1;
      busy_was = spi_busy;
      spi_done = 1'b0;
      if (!rst_n) begin
        spi_busy = 1'b0;
        tidx = 0;
        continue;
      end
      if (spi_busy) begin
        if (lat == 0) begin
          spi_busy = 1'b0;
          spi_done = 1'b1;
          spi_rx_byte = pend_rx;
          done_cyc = cyc;
        end else begin
          lat--;
        end
      end
      if (spi_start) begin
        check("start_while_busy", DW'(busy_was), '0);
        mosi_q.push_back({spi_last, spi_tx_byte});
        pend_rx = flash_byte(spi_tx_byte, spi_last);
        spi_busy = 1'b1;
        lat = $urandom_range(0, 2);
      end
    end
  end

  // Expected MOSI stream for a request, from the opcode sequence rules
  function automatic void build_exp(input logic wr, input logic [AW-1:0] a,
                                    input logic [DW-1:0] d, input int polls);
    exp_q.delete();
    if (wr) exp_q.push_back({1'b1, 8'h06});
    exp_q.push_back({1'b0, wr ? 8'h02 : 8'h03});
    for (int i = 0; i < AB; i++) exp_q.push_back({1'b0, a[(AB-1-i)*8 +: 8]});
    for (int i = 0; i < DB; i++)
      exp_q.push_back({(i == DB - 1), wr ? d[(DB-1-i)*8 +: 8] : 8'h00});
    if (wr) begin
      for (int p = 0; p < polls; p++) begin
        exp_q.push_back({1'b0, 8'h05});
        exp_q.push_back({1'b1, 8'h00});
      end
    end
  endfunction

  task automatic do_req(input vec_t v);
    int            n;
    logic [DW-1:0] snap_d;
    logic          snap_e;
    wip_cfg = v.wip;
    rdsr_count = 0;
    mosi_q.delete();
    build_exp(v.wr, v.addr, v.wdata, v.exp_polls);
    n = 0;
    while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
    check("req_ready_idle", DW'(req_ready), DW'(1));
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 24'($urandom);
    req_wdata = {$urandom, $urandom, $urandom, $urandom};
    check("req_ready_busy", DW'(req_ready), '0);
    n = 0;
    while (!rsp_valid && n < 5000) begin @(posedge clk); #1; n++; end
    check("rsp_valid", DW'(rsp_valid), DW'(1));
    if (rsp_valid) begin
      check("rsp_latency", DW'(cyc - done_cyc), DW'(1));
      check("rsp_rdata", rsp_rdata, v.exp_rdata);
      check("rsp_err", DW'(rsp_err), DW'(v.exp_err));
      snap_d = rsp_rdata;
      snap_e = rsp_err;
      if (v.keep_valid) begin
        req_valid = 1'b1;
        req_write = 1'b0;
      end
      for (int h = 0; h < v.hold; h++) begin
        @(posedge clk); #1;
        check("hold_rdata", rsp_rdata, snap_d);
        check("hold_err", DW'(rsp_err), DW'(snap_e));
        check("hold_valid", DW'(rsp_valid), DW'(1));
        if (v.keep_valid) begin
          check("hold_req_ready", DW'(req_ready), '0);
          check("hold_no_start", DW'(spi_start), '0);
        end
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      check("rsp_once", DW'(rsp_valid), '0);
      check("idle_after_rsp", DW'(req_ready), DW'(1));
    end
    check("mosi_len", DW'(mosi_q.size()), DW'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < mosi_q.size(); i++)
      check($sformatf("mosi_byte%0d", i), DW'(mosi_q[i]), DW'(exp_q[i]));
    check("rdsr_count", DW'(rdsr_count), DW'(v.exp_polls));
  endtask

  initial begin
    vec_t          vecs [5];
    vec_t          v;
    vec_t          rv;
    int            n;
    logic [DW-1:0] r;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[32'h1234 + i] = 8'(i);

    vecs[0] = '{wr:1'b0, addr:24'h001234, wdata:'0, wip:0,
                exp_rdata:128'h000102030405060708090A0B0C0D0E0F, exp_err:1'b0,
                exp_polls:0, hold:0, keep_valid:1'b0};
    vecs[1] = '{wr:1'b1, addr:24'h000100, wdata:{16{8'hA5}}, wip:0,
                exp_rdata:'0, exp_err:1'b0, exp_polls:1, hold:2, keep_valid:1'b0};
    vecs[2] = '{wr:1'b1, addr:24'h000200, wdata:128'h0123456789ABCDEF_FEDCBA9876543210, wip:3,
                exp_rdata:'0, exp_err:1'b0, exp_polls:4, hold:0, keep_valid:1'b0};
    vecs[3] = '{wr:1'b0, addr:24'h000100, wdata:'0, wip:0,
                exp_rdata:{16{8'hA5}}, exp_err:1'b0, exp_polls:0, hold:10, keep_valid:1'b1};
    vecs[4] = '{wr:1'b0, addr:24'h000200, wdata:'0, wip:0,
                exp_rdata:128'h0123456789ABCDEF_FEDCBA9876543210, exp_err:1'b0,
                exp_polls:0, hold:1, keep_valid:1'b0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", DW'(rsp_valid), '0);
    check("rst_rsp_rdata", rsp_rdata, '0);
    check("rst_rsp_err", DW'(rsp_err), '0);
    check("rst_spi_start", DW'(spi_start), '0);
    check("rst_spi_tx_byte", DW'(spi_tx_byte), '0);
    check("rst_spi_last", DW'(spi_last), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_req_ready", DW'(req_ready), DW'(1));
    check("post_rst_no_start", DW'(spi_start), '0);

    foreach (vecs[i]) do_req(vecs[i]);

    // Reset while the second address byte is outstanding
    mosi_q.delete();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 24'h00ABCD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (mosi_q.size() < 3 && n < 200) begin @(posedge clk); #1; n++; end
    check("reach_addr_byte2", DW'(mosi_q.size()), DW'(3));
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_rsp_valid", DW'(rsp_valid), '0);
    check("midrst_spi_start", DW'(spi_start), '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_req_ready", DW'(req_ready), DW'(1));
    do_req(vecs[0]);

`ifdef FLASH_POLL_TIMEOUT_EN
    // WIP stuck: exactly POLL_LIMIT polls then an error response
    v = '{wr:1'b1, addr:24'h000300, wdata:{8{16'h5A3C}}, wip:1000000,
          exp_rdata:'0, exp_err:1'b1, exp_polls:PL, hold:1, keep_valid:1'b0};
    do_req(v);
`endif

    // Random program/readback pairs and reads of untouched locations
    for (int it = 0; it < 8; it++) begin
      a = 24'($urandom);
      d = {$urandom, $urandom, $urandom, $urandom};
      v = '{wr:1'b1, addr:a, wdata:d, wip:int'($urandom_range(0, 3)), exp_rdata:'0,
            exp_err:1'b0, exp_polls:0, hold:int'($urandom_range(0, 3)), keep_valid:1'b0};
      v.exp_polls = v.wip + 1;
      do_req(v);
      rv = '{wr:1'b0, addr:a, wdata:'0, wip:0, exp_rdata:d, exp_err:1'b0,
             exp_polls:0, hold:int'($urandom_range(0, 3)), keep_valid:1'b0};
      do_req(rv);
      a = 24'($urandom);
      r = '0;
      for (int i = 0; i < DB; i++) r = {r[DW-9:0], mem_rd(int'(a) + i)};
      rv = '{wr:1'b0, addr:a, wdata:'0, wip:0, exp_rdata:r, exp_err:1'b0,
             exp_polls:0, hold:int'($urandom_range(0, 3)), keep_valid:1'b0};
      do_req(rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
